pio_master: RTL and testbench
=============================

Name: pio_master

Overview:
- Avalon-MM initiator that drives the team's register-mapped PIO slaves, e.g. a 4-bit output port at address 0 with combinational readback.
- Accepts single read/write commands on a valid/ready command port, issues one bus transaction per command, and returns read data on a valid/ready response port.
- Sits between the control logic (test sequencer or game FSM) and the PIO slaves, replacing direct processor access for hardware-only paths.

Parameters:
- ADDR_W, 2, width of the bus address.
- DATA_W, 32, width of the bus write/read data.
- READ_LATENCY, 0, cycles from the read strobe to valid readdata. Legal range 0..3; 0 means readdata is sampled in the strobe cycle.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  ADDR_W  target register address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  captured read data.
- address  out  ADDR_W  bus address.
- chipselect  out  1  bus select, active-high.
- write_n  out  1  bus write strobe, active-low.
- read_n  out  1  bus read strobe, active-low.
- writedata  out  DATA_W  bus write data.
- readdata  in  DATA_W  bus read data from the slave.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, active-high, sampled on the rising edge of clk) forces state IDLE and clears all registers. Output values while reset is high and after it is released:
  - cmd_ready=1 after release (held 0 while reset is high).
  - chipselect=0, write_n=1, read_n=1.
  - address=0, writedata=0.
  - rsp_valid=0, rsp_rdata=0, busy=0.
- All bus outputs are registered; no combinational path from cmd_* to bus pins.
- cmd_ready = (state==IDLE) and not reset. A command is accepted on a clock edge where cmd_valid and cmd_ready are both 1. Address and write data are latched at that edge.
- State IDLE: on accept, go to WR if cmd_write=1, otherwise go to RD.
- State WR (exactly 1 cycle):
  - chipselect=1, write_n=0, read_n=1.
  - address and writedata hold the latched values.
  - Next state IDLE. Writes produce no response.
- State RD (exactly 1 cycle):
  - chipselect=1, read_n=0, write_n=1, address = latched value.
  - If READ_LATENCY=0: capture readdata into rsp_rdata at the end of this cycle and go to RESP.
  - Otherwise: load the wait counter with READ_LATENCY-1 and go to RWAIT.
- State RWAIT:
  - chipselect=0, both strobes high, address held.
  - Counter decrements each cycle.
  - When counter==0, capture readdata that cycle and go to RESP.
  - Total strobe-to-capture = READ_LATENCY cycles.
- State RESP:
  - rsp_valid=1, with rsp_rdata stable.
  - On rsp_valid and rsp_ready: go to IDLE; rsp_valid=0 the next cycle.
  - rsp_ready low holds RESP indefinitely, with data stable.
- Timing:
  - Write: accept edge at N, strobe in cycle N+1, cmd_ready high again at N+2. Throughput is 1 write per 2 cycles.
  - Read with READ_LATENCY=0 and rsp_ready held high: accept at N, strobe N+1, rsp_valid N+2, next accept N+3.
- writedata keeps its last value outside WR. rsp_rdata keeps its last captured value after the handshake.
- cmd_valid asserted while not in IDLE: ignored (cmd_ready=0). The upstream must hold the command until accepted.
- Reset mid-transaction (WR, RD, RWAIT or RESP): the transaction is abandoned. Strobes deassert and rsp_valid clears at that edge, and no response is ever produced for it.
- The wait counter is 2 bits wide; READ_LATENCY above 3 is illegal and is flagged by a simulation-only check.
- Address wrap: the full ADDR_W is forwarded unmodified. The slave decodes unused addresses (e.g. reads 0).

Test Plan:
1. Reset, then a write command with address=0, wdata=0x0000000A -> exactly one cycle with chipselect=1, write_n=0, address=0, writedata=0x0000000A. The slave model's out_port becomes 4'hA. rsp_valid stays 0.
2. After scenario 1, read of address 0 with READ_LATENCY=0 -> one cycle with read_n=0. The next cycle gives rsp_valid=1 and rsp_rdata=0x0000000A. A read of address 1 returns 0x00000000.
3. READ_LATENCY=2, slave model drives readdata=0x5 two cycles after the strobe -> rsp_rdata=0x00000005. Strobe-to-rsp_valid is 3 cycles, and chipselect=0 during RWAIT.
4. Read completes with rsp_ready held 0 for 4 cycles -> rsp_valid stays 1 with data stable, cmd_ready stays 0, and a pending cmd_valid is not accepted. When rsp_ready=1, the block returns to IDLE the next cycle.
5. cmd_valid held high with writes 0x1, 0x2, 0x3 back-to-back -> strobes spaced 2 cycles apart, writedata in order 0x1, 0x2, 0x3, and out_port ends at 4'h3.
6. Reset asserted in RWAIT (READ_LATENCY=3) -> no rsp_valid ever appears for that read, and all outputs take their reset values. A new write after release behaves as in scenario 1.

Source files
------------

// File: rtl/pio_master.sv
// pio_master: Avalon-MM initiator turning single valid/ready commands into one PIO bus
// transaction each, with read data returned on a valid/ready response port.
module pio_master #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write_n,
    output logic              read_n,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, RESP} state_t;

    localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

    if (READ_LATENCY < 0 || READ_LATENCY > 3) begin : g_bad_latency
        $error("pio_master: READ_LATENCY %0d outside 0..3", READ_LATENCY);
    end

    state_t     state, state_next;
    logic [1:0] cnt;
    logic       accept, capture;

    assign cmd_ready = state == IDLE && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign capture   = READ_LATENCY == 0 ? state == RD : state == RWAIT && cnt == 2'd0;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = cmd_write ? WR : RD;
            WR:      state_next = IDLE;
            RD:      state_next = READ_LATENCY == 0 ? RESP : RWAIT;
            RWAIT:   if (cnt == 2'd0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Bus strobes decode the next state so they are registered yet line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            address    <= '0;
            writedata  <= '0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            read_n     <= 1'b1;
            rsp_rdata  <= '0;
        end else begin
            chipselect <= state_next == WR || state_next == RD;
            write_n    <= state_next != WR;
            read_n     <= state_next != RD;
            if (accept)
                address <= cmd_address;
            if (accept && cmd_write)
                writedata <= cmd_wdata;
            if (state == RD)
                cnt <= WAIT_INIT;
            else if (state == RWAIT)
                cnt <= cnt - 2'd1;
            if (capture)
                rsp_rdata <= readdata;
        end
    end
endmodule

// File: tb/tb_pio_master.sv
// tb_pio_master: three pio_master instances (read latency 0, 2, 3), each on a 4-bit PIO slave
// model, checked cycle by cycle against a transaction-level reference.
module tb_pio_master;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid [3];
    logic        cmd_write [3];
    logic        rsp_ready [3];
    logic [1:0]  cmd_address [3];
    logic [31:0] cmd_wdata [3];
    logic        cmd_ready [3];
    logic        rsp_valid [3];
    logic        cs [3];
    logic        wn [3];
    logic        rn [3];
    logic        busy [3];
    logic [1:0]  addr [3];
    logic [31:0] wd [3];
    logic [31:0] rdata [3];
    logic [3:0]  out_port [3];

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic [3:0]  ref_port [3];
    logic [31:0] ref_wd [3];

    for (genvar g = 0; g < 3; g++) begin : s
        localparam int L = g == 0 ? 0 : g + 1;
        logic [3:0]  port_q;
        logic [31:0] cv, rd_bus;
        logic [31:0] dl [3];

        pio_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(L)) dut (
            .clk(clk), .reset(reset),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_write(cmd_write[g]),
            .cmd_address(cmd_address[g]), .cmd_wdata(cmd_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rdata[g]),
            .address(addr[g]), .chipselect(cs[g]), .write_n(wn[g]), .read_n(rn[g]),
            .writedata(wd[g]), .readdata(rd_bus), .busy(busy[g])
        );

        always_ff @(posedge clk) begin
            if (reset)
                port_q <= 4'd0;
            else if (cs[g] && !wn[g] && addr[g] == 2'd0)
                port_q <= wd[g][3:0];
        end

        // Outside the strobe the slave drives junk, so a mistimed capture is visible.
        assign cv = !rn[g] ? (addr[g] == 2'd0 ? {28'd0, port_q} : 32'd0) : 32'hDEAD_BEEF;

        always_ff @(posedge clk) begin
            dl[0] <= cv;
            dl[1] <= dl[0];
            dl[2] <= dl[1];
        end

        assign rd_bus      = L == 0 ? cv : dl[L == 0 ? 0 : L - 1];
        assign out_port[g] = port_q;
    end

    function automatic int lat(input int i);
        return i == 0 ? 0 : i + 1;
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s inst%0d observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input int i, input logic obs, input logic exp);
        chk(tag, i, {31'd0, obs}, {31'd0, exp});
    endtask

    task automatic chk_reset_vals(input int i, input logic rdy);
        chk1("rst_cmd_ready", i, cmd_ready[i], rdy);
        chk1("rst_chipselect", i, cs[i], 1'b0);
        chk1("rst_write_n", i, wn[i], 1'b1);
        chk1("rst_read_n", i, rn[i], 1'b1);
        chk1("rst_rsp_valid", i, rsp_valid[i], 1'b0);
        chk1("rst_busy", i, busy[i], 1'b0);
        chk("rst_address", i, 32'(addr[i]), 0);
        chk("rst_writedata", i, wd[i], 0);
        chk("rst_rsp_rdata", i, rdata[i], 0);
    endtask

    // Called at a falling edge with the instance idle; returns at the falling edge where it is idle again.
    // cmd_valid is left high, as an upstream holding its next command would.
    task automatic xact(input int i, input bit wr, input logic [1:0] a, input logic [31:0] d, input int stall);
        logic [31:0] exp;
        exp = a == 2'd0 ? {28'd0, ref_port[i]} : 32'd0;
        cmd_valid[i] = 1'b1;
        cmd_write[i] = wr;
        cmd_address[i] = a;
        cmd_wdata[i] = d;
        rsp_ready[i] = stall == 0;
        chk1("accept_ready", i, cmd_ready[i], 1'b1);
        @(negedge clk);
        if (wr)
            ref_wd[i] = d;
        chk1("strobe_cs", i, cs[i], 1'b1);
        chk1("strobe_write_n", i, wn[i], !wr);
        chk1("strobe_read_n", i, rn[i], wr);
        chk("strobe_addr", i, 32'(addr[i]), 32'(a));
        chk("strobe_writedata", i, wd[i], ref_wd[i]);
        chk1("strobe_busy", i, busy[i], 1'b1);
        chk1("strobe_cmd_ready", i, cmd_ready[i], 1'b0);
        if (wr) begin
            if (a == 2'd0)
                ref_port[i] = d[3:0];
            @(negedge clk);
        end else begin
            for (int k = 0; k < lat(i); k++) begin
                @(negedge clk);
                chk1("rwait_cs", i, cs[i], 1'b0);
                chk1("rwait_read_n", i, rn[i], 1'b1);
                chk1("rwait_rsp_valid", i, rsp_valid[i], 1'b0);
                chk("rwait_addr", i, 32'(addr[i]), 32'(a));
            end
            @(negedge clk);
            for (int k = 0; k <= stall; k++) begin
                chk1("rsp_valid", i, rsp_valid[i], 1'b1);
                chk("rsp_rdata", i, rdata[i], exp);
                chk1("resp_cs", i, cs[i], 1'b0);
                chk1("resp_cmd_ready", i, cmd_ready[i], 1'b0);
                if (k == stall)
                    rsp_ready[i] = 1'b1;
                @(negedge clk);
            end
            chk("rdata_kept", i, rdata[i], exp);
        end
        chk1("idle_cs", i, cs[i], 1'b0);
        chk1("idle_write_n", i, wn[i], 1'b1);
        chk1("idle_read_n", i, rn[i], 1'b1);
        chk1("idle_rsp_valid", i, rsp_valid[i], 1'b0);
        chk1("idle_cmd_ready", i, cmd_ready[i], 1'b1);
        chk1("idle_busy", i, busy[i], 1'b0);
        chk("out_port", i, 32'(out_port[i]), 32'(ref_port[i]));
        chk("writedata_kept", i, wd[i], ref_wd[i]);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic seen;
        for (int i = 0; i < 3; i++) begin
            cmd_valid[i] = 1'b0;
            cmd_write[i] = 1'b0;
            cmd_address[i] = 2'd0;
            cmd_wdata[i] = 32'd0;
            rsp_ready[i] = 1'b0;
            ref_port[i] = 4'd0;
            ref_wd[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_reset_vals(i, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk_reset_vals(i, 1'b1);

        xact(0, 1'b1, 2'd0, 32'h0000_000A, 0);
        xact(0, 1'b0, 2'd0, 32'd0, 0);
        xact(0, 1'b0, 2'd1, 32'd0, 0);
        xact(0, 1'b0, 2'd0, 32'd0, 4);
        xact(0, 1'b1, 2'd0, 32'h1, 0);
        xact(0, 1'b1, 2'd0, 32'h2, 0);
        xact(0, 1'b1, 2'd0, 32'h3, 0);
        cmd_valid[0] = 1'b0;
        chk("out_port_final", 0, 32'(out_port[0]), 32'h3);

        xact(1, 1'b1, 2'd0, 32'h5, 0);
        xact(1, 1'b0, 2'd0, 32'd0, 0);
        cmd_valid[1] = 1'b0;

        xact(2, 1'b1, 2'd0, 32'h9, 0);
        cmd_write[2] = 1'b0;
        @(negedge clk);
        chk1("abort_strobe_read_n", 2, rn[2], 1'b0);
        cmd_valid[2] = 1'b0;
        @(negedge clk);
        chk1("abort_rwait_cs", 2, cs[2], 1'b0);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk_reset_vals(i, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ref_port[i] = 4'd0;
            ref_wd[i] = 32'd0;
        end
        @(negedge clk);
        chk_reset_vals(2, 1'b1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= rsp_valid[2];
        end
        chk1("abort_no_rsp", 2, seen, 1'b0);
        xact(2, 1'b1, 2'd0, 32'h0000_000A, 0);
        cmd_valid[2] = 1'b0;

        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 15; n++) begin
                logic [1:0] a;
                a = $urandom_range(0, 1) != 0 ? 2'd0 : 2'($urandom_range(0, 3));
                xact(i, $urandom_range(0, 1) != 0, a, $urandom, int'($urandom_range(0, 2)));
            end
            cmd_valid[i] = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
